mcm_rx_coord: RTL and testbench

//  Write-address coordinator for MCM answer frames. Watches the async byte-valid strobe from the
//  MCM receiver, counts bytes and drives the write address/strobe into frame RAM.

---
 rtl/mcm_rx_coord.sv | 151 +++++++++++++++
 tb/tb_mcm_rx_coord.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcm_rx_coord.sv
// Write-address coordinator for MCM answer frames: synchronises the receiver byte strobe,
// counts bytes and drives the frame-RAM address/strobe with done, timeout and overrun flags.
module mcm_rx_coord #(
    parameter int ADDR_W    = 8,
    parameter int FRAME_LEN = 144,
    parameter int BASE_ADDR = 0,
    parameter int SYNC_STG  = 2,
    parameter int TIMEOUT   = 4096,
    localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iRQ,
    input  logic              iVal,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oWe,
    output logic [CNT_W-1:0]  oCount,
    output logic              oBusy,
    output logic              oDone,
    output logic              oTimeout,
    output logic              oOverrun
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN);
    localparam logic [TMR_W-1:0]  TMR_ZERO  = TMR_W'(0);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             r_state;
    logic [SYNC_STG-1:0] r_sync;
    logic               r_vs_d;
    logic [TMR_W-1:0]   r_tmr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic               r_overrun;

    logic w_vs;
    logic w_rise;
    logic w_fall;
    logic w_expire;

    assign w_vs     = r_sync[SYNC_STG-1];
    assign w_rise   = w_vs & ~r_vs_d;
    assign w_fall   = ~w_vs & r_vs_d;
    // A zero TIMEOUT parameter disables expiry entirely.
    assign w_expire = (TIMEOUT > 0) && (r_tmr == TMR_LAST);

    // Synchroniser chain for the asynchronous byte strobe plus the delayed copy for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {SYNC_STG{1'b0}};
            r_vs_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], iVal};
            r_vs_d <= w_vs;
        end
    end

    // Frame FSM: restart, byte counting, write strobe and address advance, sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_addr    <= ADDR_BASE;
            r_we      <= 1'b0;
            r_cnt     <= CNT_ZERO;
            r_tmr     <= TMR_ZERO;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else if (iRQ) begin
            r_state   <= S_WAIT;
            r_addr    <= ADDR_BASE;
            r_we      <= 1'b0;
            r_cnt     <= CNT_ZERO;
            r_tmr     <= TMR_ZERO;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // The address moves on the cycle after the strobe, so the RAM sees a stable pair.
            if (r_we) begin
                r_addr <= r_addr + ADDR_ONE;
            end
            if (w_rise || w_fall) begin
                r_tmr <= TMR_ZERO;
            end
            case (r_state)
                S_WAIT: begin
                    if (w_rise) begin
                        if (r_cnt != CNT_LAST) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end else if (w_fall) begin
                        r_we <= 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_expire) begin
                        r_state   <= S_ERR;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + TMR_ONE;
                    end
                end
                S_DONE: begin
                    if (w_rise) begin
                        r_overrun <= 1'b1;
                    end
                end
                S_IDLE, S_ERR: begin
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign oAddr    = r_addr;
    assign oWe      = r_we;
    assign oCount   = r_cnt;
    assign oBusy    = r_busy;
    assign oDone    = r_done;
    assign oTimeout = r_timeout;
    assign oOverrun = r_overrun;

endmodule

// File: tb/tb_mcm_rx_coord.sv
// Self-checking bench for mcm_rx_coord: a default 144-byte instance and a small wrapping
// 16-byte instance (deeper synchroniser, timeout disabled) checked against expected frame behaviour.
module tb_mcm_rx_coord;

    logic clk = 1'b0;
    logic reset;
    logic a_irq, a_val, b_irq, b_val;

    logic [7:0] a_addr;
    logic       a_we;
    logic [7:0] a_cnt;
    logic       a_busy, a_done, a_to, a_ov;
    logic [3:0] b_addr;
    logic       b_we;
    logic [4:0] b_cnt;
    logic       b_busy, b_done, b_to, b_ov;

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];

    typedef struct {
        bit irq;
        int pulses;
        int exp_addr;
        int exp_cnt;
        int exp_busy;
        int exp_done;
        int exp_ov;
        int exp_writes;
    } vec_t;

    always #5 clk = ~clk;

    mcm_rx_coord #(.ADDR_W(8), .FRAME_LEN(144), .BASE_ADDR(0), .SYNC_STG(2), .TIMEOUT(4096)) u_a (
        .clk(clk), .reset(reset), .iRQ(a_irq), .iVal(a_val),
        .oAddr(a_addr), .oWe(a_we), .oCount(a_cnt), .oBusy(a_busy),
        .oDone(a_done), .oTimeout(a_to), .oOverrun(a_ov)
    );

    mcm_rx_coord #(.ADDR_W(4), .FRAME_LEN(16), .BASE_ADDR(8), .SYNC_STG(3), .TIMEOUT(0)) u_b (
        .clk(clk), .reset(reset), .iRQ(b_irq), .iVal(b_val),
        .oAddr(b_addr), .oWe(b_we), .oCount(b_cnt), .oBusy(b_busy),
        .oDone(b_done), .oTimeout(b_to), .oOverrun(b_ov)
    );

    // Every strobed RAM write is logged, one entry per strobe cycle.
    always @(negedge clk) begin
        if (a_we === 1'b1) qa.push_back(int'(a_addr));
        if (b_we === 1'b1) qb.push_back(int'(b_addr));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_val(input bit sel, input logic v);
        if (sel) b_val = v;
        else     a_val = v;
    endtask

    task automatic set_irq(input bit sel, input logic v);
        if (sel) b_irq = v;
        else     a_irq = v;
    endtask

    task automatic pulse(input bit sel, input int hi, input int lo);
        set_val(sel, 1'b1);
        repeat (hi) @(posedge clk);
        #1 set_val(sel, 1'b0);
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic req(input bit sel, input int n);
        set_irq(sel, 1'b1);
        repeat (n) @(posedge clk);
        #1 set_irq(sel, 1'b0);
    endtask

    task automatic chk_out(input bit sel, input string tag, input int addr, input int cnt,
                           input int busy, input int done, input int tmo, input int ov);
        if (sel) begin
            chk({tag, " addr"},    32'(b_addr), addr);
            chk({tag, " count"},   32'(b_cnt),  cnt);
            chk({tag, " busy"},    32'(b_busy), busy);
            chk({tag, " done"},    32'(b_done), done);
            chk({tag, " timeout"}, 32'(b_to),   tmo);
            chk({tag, " overrun"}, 32'(b_ov),   ov);
        end else begin
            chk({tag, " addr"},    32'(a_addr), addr);
            chk({tag, " count"},   32'(a_cnt),  cnt);
            chk({tag, " busy"},    32'(a_busy), busy);
            chk({tag, " done"},    32'(a_done), done);
            chk({tag, " timeout"}, 32'(a_to),   tmo);
            chk({tag, " overrun"}, 32'(a_ov),   ov);
        end
    endtask

    task automatic chk_writes(input bit sel, input string tag, input int start, input int n,
                              input int first, input int modv);
        int got;
        got = sel ? (qb.size() - start) : (qa.size() - start);
        chk({tag, " writes"}, got, n);
        for (int k = 0; k < n && k < got; k++) begin
            chk({tag, " waddr"}, sel ? qb[start + k] : qa[start + k], (first + k) % modv);
        end
    endtask

    initial begin
        vec_t tbl[5];
        int   n0;
        int   m_addr, m_cnt;
        bit   m_act, m_done, m_ov;

        reset = 1'b0;
        a_irq = 1'b0; a_val = 1'b0; b_irq = 1'b0; b_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out(1'b0, "rst A", 0, 0, 0, 0, 0, 0);
        chk("rst A we", 32'(a_we), 0);
        chk_out(1'b1, "rst B", 8, 0, 0, 0, 0, 0);
        chk("rst B we", 32'(b_we), 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Pulses without any request must be ignored.
        n0 = qa.size();
        repeat (3) pulse(1'b0, 4, 4);
        chk_out(1'b0, "norq", 0, 0, 0, 0, 0, 0);
        chk_writes(1'b0, "norq", n0, 0, 0, 256);

        // Full frame, overrun after completion, then restart clearing the flags.
        tbl[0] = '{1'b1, 0,   0,   0,   1, 0, 0, 0};
        tbl[1] = '{1'b0, 143, 143, 143, 1, 0, 0, 143};
        tbl[2] = '{1'b0, 1,   144, 144, 0, 1, 0, 1};
        tbl[3] = '{1'b0, 3,   144, 144, 0, 1, 1, 0};
        tbl[4] = '{1'b1, 0,   0,   0,   1, 0, 0, 0};
        for (int r = 0; r < 5; r++) begin
            n0 = qa.size();
            if (tbl[r].irq) req(1'b0, 2);
            repeat (tbl[r].pulses) pulse(1'b0, 4, 4);
            chk_out(1'b0, $sformatf("vec%0d", r), tbl[r].exp_addr, tbl[r].exp_cnt,
                    tbl[r].exp_busy, tbl[r].exp_done, 0, tbl[r].exp_ov);
            chk_writes(1'b0, $sformatf("vec%0d", r), n0, tbl[r].exp_writes,
                       tbl[r].exp_addr - tbl[r].exp_writes, 256);
        end

        // Timeout: 4096 idle cycles after the last synchronised edge.
        req(1'b0, 1);
        n0 = qa.size();
        repeat (10) pulse(1'b0, 4, 4);
        chk_writes(1'b0, "tmo", n0, 10, 0, 256);
        repeat (4094) @(posedge clk);
        #1;
        chk_out(1'b0, "tmo early", 10, 10, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk_out(1'b0, "tmo", 10, 10, 0, 0, 1, 0);

        // Restart in the middle of a frame while the strobe is high.
        req(1'b0, 1);
        chk_out(1'b0, "t4 rq", 0, 0, 1, 0, 0, 0);
        repeat (50) pulse(1'b0, 4, 4);
        a_val = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t4 cnt51", 32'(a_cnt), 51);
        n0 = qa.size();
        a_irq = 1'b1;
        repeat (2) @(posedge clk);
        #1 a_val = 1'b0;
        repeat (5) @(posedge clk);
        #1 a_irq = 1'b0;
        chk_out(1'b0, "t4 mid", 0, 0, 1, 0, 0, 0);
        chk_writes(1'b0, "t4 mid", n0, 0, 0, 256);
        n0 = qa.size();
        repeat (144) pulse(1'b0, 4, 4);
        chk_out(1'b0, "t4 end", 144, 144, 0, 1, 0, 0);
        chk_writes(1'b0, "t4 end", n0, 144, 0, 256);

        // Fall with no preceding rise right after a restart still writes.
        a_irq = 1'b1;
        a_val = 1'b1;
        repeat (5) @(posedge clk);
        #1 a_irq = 1'b0;
        @(posedge clk);
        n0 = qa.size();
        #1 a_val = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_out(1'b0, "glitch", 1, 0, 1, 0, 0, 0);
        chk_writes(1'b0, "glitch", n0, 1, 0, 256);

        // Small wrapping frame on the second instance.
        req(1'b1, 1);
        n0 = qb.size();
        repeat (15) pulse(1'b1, 4, 5);
        chk_out(1'b1, "wrap15", 7, 15, 1, 0, 0, 0);
        pulse(1'b1, 4, 5);
        chk_out(1'b1, "wrap16", 8, 16, 0, 1, 0, 0);
        chk_writes(1'b1, "wrap", n0, 16, 8, 16);
        req(1'b1, 1);
        repeat (300) @(posedge clk);
        #1;
        chk_out(1'b1, "notmo", 8, 0, 1, 0, 0, 0);

        // Randomised traffic against a frame-level model.
        m_act = 1'b1; m_done = 1'b0; m_ov = 1'b0; m_cnt = 0; m_addr = 8;
        for (int i = 0; i < 250; i++) begin
            n0 = qb.size();
            if ($urandom_range(0, 19) == 0) begin
                req(1'b1, int'($urandom_range(1, 3)));
                m_act = 1'b1; m_done = 1'b0; m_ov = 1'b0; m_cnt = 0; m_addr = 8;
                chk_writes(1'b1, "rnd rq", n0, 0, 0, 16);
            end else begin
                pulse(1'b1, int'($urandom_range(1, 6)), int'($urandom_range(5, 9)));
                if (m_act) begin
                    chk_writes(1'b1, "rnd byte", n0, 1, m_addr, 16);
                    m_cnt  = (m_cnt < 16) ? m_cnt + 1 : 16;
                    m_addr = (m_addr + 1) % 16;
                    if (m_cnt == 16) begin
                        m_act  = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    chk_writes(1'b1, "rnd byte", n0, 0, 0, 16);
                    if (m_done) m_ov = 1'b1;
                end
            end
            chk_out(1'b1, "rnd", m_addr, m_cnt, m_act, m_done, 0, m_ov);
        end

        // Asynchronous reset in the middle of a frame.
        req(1'b0, 1);
        repeat (5) pulse(1'b0, 4, 4);
        a_val = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_out(1'b0, "arst A", 0, 0, 0, 0, 0, 0);
        chk("arst A we", 32'(a_we), 0);
        chk_out(1'b1, "arst B", 8, 0, 0, 0, 0, 0);
        a_val = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_out(1'b0, "post rst", 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
